// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
// Also holds the own-address match helper used by the address phase.
package i2c_pkg;

  localparam int   I2C_ADDR_W = 7;
  localparam int   I2C_BYTE_W = 8;
  localparam logic RW_READ    = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_IGNORE,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WR_MEM,
    ST_WDATA_ACK,
    ST_RD_FETCH,
    ST_RDATA,
    ST_MACK
  } i2c_tgt_state_e;

  // General call (address 0) is never claimed.
  function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] b,
                                      input logic [I2C_ADDR_W-1:0] own);
    return (b[I2C_BYTE_W-1:1] == own) && (b[I2C_BYTE_W-1:1] != '0);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with edge, START and STOP detection; events appear SYNC_STAGES clks
// after the pin change and are consumed on the next edge. No backpressure: pure observer.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;

  // Reset to the idle-bus level so release from reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target serving byte writes/reads to a memory port; pin-to-action SYNC_STAGES+1 clks.
// Stretches SCL while a memory access is outstanding; mem_req held until mem_ack.
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h32,
  parameter int         AW          = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          scl_oe,
  output logic          sda_oe,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack,
  output logic          busy
);

  i2c_tgt_state_e          state;
  logic [2:0]              bit_cnt;
  logic [I2C_BYTE_W-1:0]   shreg;
  logic [AW-1:0]           ptr;
  logic                    ack_phase;
  logic                    rw;
  logic                    scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic [I2C_BYTE_W-1:0]   rx_byte;
  logic                    last_bit;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign rx_byte  = {shreg[I2C_BYTE_W-2:0], sda_s};
  assign last_bit = (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      ack_phase <= 1'b0;
      rw        <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      // An outstanding request always completes, even after STOP or repeated START.
      if (mem_req && mem_ack) mem_req <= 1'b0;

      if (stop_det) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        sda_oe    <= 1'b0;
        scl_oe    <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else if (start_det) begin
        state     <= ST_ADDR;
        sda_oe    <= 1'b0;
        scl_oe    <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else begin
        unique case (state)
          ST_ADDR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              ack_phase <= 1'b0;
              if (addr_match(rx_byte, SLAVE_ADDR)) begin
                state <= ST_ADDR_ACK;
                rw    <= rx_byte[0];
                busy  <= 1'b1;
              end else begin
                state <= ST_IGNORE;
                busy  <= 1'b0;
              end
            end
          end

          ST_PTR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              ptr       <= AW'(rx_byte);
              ack_phase <= 1'b0;
              state     <= ST_PTR_ACK;
            end
          end

          ST_WDATA: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= ptr;
              mem_wdata <= rx_byte;
              state     <= ST_WR_MEM;
            end
          end

          // If SCL already fell, the ACK slot is open: drive ACK now, release SCL next clk.
          ST_WR_MEM: begin
            if (mem_ack) begin
              ptr   <= ptr + AW'(1);
              state <= ST_WDATA_ACK;
              if (scl_oe || scl_fall) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
              end
            end else if (scl_fall) begin
              scl_oe <= 1'b1;
            end
          end

          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_oe) scl_oe <= 1'b0;
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                if (state == ST_ADDR_ACK && rw == RW_READ) begin
                  state    <= ST_RD_FETCH;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= ptr;
                  scl_oe   <= 1'b1;
                end else if (state == ST_ADDR_ACK) begin
                  state <= ST_PTR;
                end else begin
                  state <= ST_WDATA;
                end
              end
            end
          end

          // Entered on an SCL fall, so SCL is already stretched; MSB goes out with the data.
          ST_RD_FETCH: if (mem_ack) begin
            shreg   <= mem_rdata;
            sda_oe  <= ~mem_rdata[7];
            bit_cnt <= '0;
            state   <= ST_RDATA;
          end

          ST_RDATA: begin
            if (scl_oe) scl_oe <= 1'b0;
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                ack_phase <= 1'b0;
                state     <= ST_MACK;
              end
            end else if (scl_fall) begin
              sda_oe <= ~shreg[I2C_BYTE_W-2];
              shreg  <= {shreg[I2C_BYTE_W-2:0], 1'b0};
            end
          end

          ST_MACK: begin
            if (!ack_phase) begin
              if (scl_fall) begin
                sda_oe    <= 1'b0;
                ack_phase <= 1'b1;
              end
            end else if (scl_rise && sda_s) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              ack_phase <= 1'b0;
            end else if (scl_fall) begin
              ptr       <= ptr + AW'(1);
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= ptr + AW'(1);
              scl_oe    <= 1'b1;
              ack_phase <= 1'b0;
              state     <= ST_RD_FETCH;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed plus randomized I2C master transactions against a transaction-level memory model.
module tb_i2c_target_responder;
  import i2c_pkg::*;

  localparam int H = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       scl_line, sda_line;
  logic       scl_oe, sda_oe, mem_req, mem_we, busy;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;

  int         tests = 0;
  int         failed = 0;
  logic [7:0] mem [256];
  logic [7:0] dbuf [8];
  int         ack_delay = 2;
  int         dly_cnt = 0;
  int         rd_cnt = 0;
  logic [15:0] wr_log [$];
  int         stretch_last, max_stretch;

  always #5 clk = ~clk;

  assign scl_line = scl_m & ~scl_oe;
  assign sda_line = sda_m & ~sda_oe;

  i2c_target_responder dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_line),
    .sda_i     (sda_line),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy)
  );

  // Memory controller model: acks after ack_delay clks, logs writes, serves reads from mem[].
  always @(posedge clk) begin
    if (rst) begin
      mem_ack <= 1'b0;
      dly_cnt <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack) begin
        if (dly_cnt >= ack_delay) begin
          mem_ack <= 1'b1;
          dly_cnt <= 0;
          if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
          else begin
            mem_rdata <= mem[mem_addr];
            rd_cnt    <= rd_cnt + 1;
          end
        end else begin
          dly_cnt <= dly_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int n = 0;
    scl_m = 1'b1;
    @(negedge clk);
    while (scl_line !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    stretch_last = n;
    if (n > max_stretch) max_stretch = n;
    if (n >= 2000) check("scl_release_timeout", {31'd0, scl_line}, 32'd1);
  endtask

  task automatic pulse(input logic b, output logic s);
    wclk(2);
    sda_m = b;
    wclk(H);
    scl_high();
    wclk(H);
    s = sda_line;
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    wclk(2);
    sda_m = 1'b1;
    wclk(H);
    scl_high();
    wclk(H);
    sda_m = 1'b0;
    wclk(H);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wclk(2);
    sda_m = 1'b0;
    wclk(H);
    scl_high();
    wclk(H);
    sda_m = 1'b1;
    wclk(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) pulse(b[i], s);
    pulse(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      pulse(1'b1, s);
      b = {b[6:0], s};
    end
    pulse(nack, s);
  endtask

  // Pointer write then n data bytes from dbuf; expected writes land at ptr+i mod 256.
  task automatic xfer_write(input logic [7:0] ptr, input int n, input string tag);
    int   base;
    logic a;
    base = wr_log.size();
    i2c_start();
    write_byte(8'h64, a);
    check({tag, "_addr_ack"}, {31'd0, a}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    write_byte(ptr, a);
    check({tag, "_ptr_ack"}, {31'd0, a}, 32'd1);
    for (int i = 0; i < n; i++) begin
      write_byte(dbuf[i], a);
      check({tag, "_data_ack"}, {31'd0, a}, 32'd1);
      check({tag, "_stored_before_ack"}, wr_log.size() - base, i + 1);
    end
    i2c_stop();
    wclk(4);
    check({tag, "_busy_after_stop"}, {31'd0, busy}, 32'd0);
    check({tag, "_wr_count"}, wr_log.size() - base, n);
    for (int i = 0; i < n; i++)
      if (base + i < wr_log.size())
        check({tag, "_wr_entry"}, {16'd0, wr_log[base + i]}, {16'd0, 8'(ptr + 8'(i)), dbuf[i]});
  endtask

  // Set pointer, repeated START in read mode, read n bytes ACKing all but the last.
  task automatic xfer_read(input logic [7:0] ptr, input int n, input int dly, input string tag);
    int         rbase;
    logic       a;
    logic [7:0] b;
    ack_delay = dly;
    rbase = rd_cnt;
    i2c_start();
    write_byte(8'h64, a);
    write_byte(ptr, a);
    i2c_start();
    write_byte(8'h65, a);
    check({tag, "_rd_addr_ack"}, {31'd0, a}, 32'd1);
    max_stretch = 0;
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, b);
      check({tag, "_rdata"}, {24'd0, b}, {24'd0, mem[8'(ptr + 8'(i))]});
    end
    wclk(6);
    check({tag, "_busy_after_nack"}, {31'd0, busy}, 32'd0);
    check({tag, "_sda_released"}, {31'd0, sda_oe}, 32'd0);
    i2c_stop();
    check({tag, "_rd_count"}, rd_cnt - rbase, n);
    if (dly >= 40) check({tag, "_stretched"}, {31'd0, max_stretch >= 15}, 32'd1);
    ack_delay = 2;
  endtask

  initial begin
    logic a;
    logic [7:0] p;
    int n;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hC8;
    mem[8'h40] = 8'h00;
    rst = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wclk(4);
    check("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    rst = 1'b0;
    wclk(10);

    dbuf[0] = 8'h78;
    xfer_write(8'h10, 1, "t1_write");

    xfer_read(8'h10, 1, 2, "t2_read");

    n = rd_cnt + wr_log.size();
    i2c_start();
    write_byte(8'h28, a);
    check("t3_mismatch_nack", {31'd0, a}, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h55, a);
    check("t3_data_nack", {31'd0, a}, 32'd0);
    check("t3_no_mem", rd_cnt + wr_log.size(), n);
    i2c_stop();
    i2c_start();
    write_byte(8'h00, a);
    check("t3_gencall_nack", {31'd0, a}, 32'd0);
    i2c_stop();

    dbuf[0] = 8'hAA;
    dbuf[1] = 8'hBB;
    xfer_write(8'hFF, 2, "t4_wrap");

    xfer_read(8'($urandom), 3, 40, "t5_stretch");

    for (int k = 0; k < 3; k++) begin
      p = 8'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) dbuf[i] = 8'($urandom);
      ack_delay = (k == 1) ? 40 : $urandom_range(0, 5);
      xfer_write(p, n, "rnd_write");
      ack_delay = 2;
      xfer_read(8'($urandom), $urandom_range(1, 4), $urandom_range(0, 6), "rnd_read");
    end

    i2c_start();
    write_byte(8'h64, a);
    write_byte(8'h40, a);
    i2c_start();
    write_byte(8'h65, a);
    for (int i = 0; i < 3; i++) pulse(1'b1, a);
    wclk(6);
    check("t6_pre_sda_oe", {31'd0, sda_oe}, 32'd1);
    check("t6_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("t6_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("t6_mem_req", {31'd0, mem_req}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_state_idle", {28'd0, dut.state}, {28'd0, ST_IDLE});
    rst = 1'b0;
    scl_m = 1'b1;
    wclk(H);
    sda_m = 1'b1;
    wclk(H);

    dbuf[0] = 8'h3C;
    xfer_write(8'h20, 1, "t6_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
